// File: rtl/cash_pkg.sv
// Shared types and constant helpers for the cash fill controller and its counters.
package cash_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_WAIT,
        FILL,
        RESPOND
    } cfc_state_t;

    // Largest value a saturating counter of the given width can hold.
    function automatic int sat_max(input int width);
        return (1 << width) - 1;
    endfunction

    // Memory-wait cycle limit for a timeout counter of the given width.
    function automatic int timeout_max(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/cfc_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at its maximum and never wraps.
module cfc_sat_counter
    import cash_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [width-1:0] count
);

    localparam logic [width-1:0] count_max = width'(sat_max(width));

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != count_max)) begin
            count <= count + width'(1);
        end
    end

endmodule

// File: rtl/cash_fill_controller.sv
// Request front-end and miss handler for fast_unordered_cash: answers hits from the cache,
// fetches misses from backing memory, fills the cache and keeps saturating hit/miss statistics.
module cash_fill_controller
    import cash_pkg::*;
#(
    parameter int address_size  = 4,
    parameter int data_size     = 4,
    parameter int timeout_width = 4,
    parameter int stat_width    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [address_size-1:0] req_address,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [data_size-1:0]    rsp_data,
    output logic                    rsp_hit,
    output logic                    rsp_error,
    output logic [address_size-1:0] cache_address,
    input  logic                    cache_hit,
    input  logic [data_size-1:0]    cache_data,
    output logic                    cache_write,
    output logic [data_size-1:0]    cache_wdata,
    output logic                    mem_req,
    output logic [address_size-1:0] mem_address,
    input  logic                    mem_ack,
    input  logic [data_size-1:0]    mem_data,
    output logic [stat_width-1:0]   hit_count,
    output logic [stat_width-1:0]   miss_count
);

    // The wait counter reaching its maximum on the next edge marks the final wait cycle.
    localparam logic [timeout_width-1:0] wait_last =
        timeout_width'(timeout_max(timeout_width) - 1);

    cfc_state_t               state, state_next;
    logic [address_size-1:0]  addr_q;
    logic [data_size-1:0]     data_q;
    logic                     hit_q, error_q;
    logic [timeout_width-1:0] wait_count;

    logic accept, lookup_hit, lookup_miss, waiting, ack_taken, timed_out, rsp_taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_next  = state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        mem_req     = 1'b0;
        cache_write = 1'b0;
        accept      = 1'b0;
        lookup_hit  = 1'b0;
        lookup_miss = 1'b0;
        waiting     = 1'b0;
        ack_taken   = 1'b0;
        timed_out   = 1'b0;
        rsp_taken   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = LOOKUP;
                end
            end
            LOOKUP: begin
                if (cache_hit) begin
                    lookup_hit = 1'b1;
                    state_next = RESPOND;
                end else begin
                    lookup_miss = 1'b1;
                    state_next  = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                mem_req = 1'b1;
                waiting = 1'b1;
                // A same-cycle ack beats the timeout.
                if (mem_ack) begin
                    ack_taken  = 1'b1;
                    state_next = FILL;
                end else if (wait_count == wait_last) begin
                    timed_out  = 1'b1;
                    state_next = RESPOND;
                end
            end
            FILL: begin
                cache_write = 1'b1;
                state_next  = RESPOND;
            end
            RESPOND: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    rsp_taken  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            data_q  <= '0;
            hit_q   <= 1'b0;
            error_q <= 1'b0;
        end else begin
            if (accept) begin
                addr_q <= req_address;
            end
            if (lookup_hit) begin
                data_q  <= cache_data;
                hit_q   <= 1'b1;
                error_q <= 1'b0;
            end
            if (lookup_miss) begin
                hit_q   <= 1'b0;
                error_q <= 1'b0;
            end
            if (ack_taken) begin
                data_q <= mem_data;
            end
            if (timed_out) begin
                data_q  <= '0;
                error_q <= 1'b1;
            end
            if (rsp_taken) begin
                error_q <= 1'b0;
            end
        end
    end

    cfc_sat_counter #(.width(stat_width)) u_hit_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (lookup_hit),
        .count (hit_count)
    );

    cfc_sat_counter #(.width(stat_width)) u_miss_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (lookup_miss),
        .count (miss_count)
    );

    cfc_sat_counter #(.width(timeout_width)) u_wait_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (lookup_miss),
        .inc   (waiting),
        .count (wait_count)
    );

    // Cache and memory see the latched address in every state so they never glitch.
    assign cache_address = addr_q;
    assign mem_address   = addr_q;
    assign cache_wdata   = data_q;
    assign rsp_data      = data_q;
    assign rsp_hit       = hit_q;
    assign rsp_error     = error_q;

endmodule

// File: tb/tb_cash_fill_controller.sv
// Self-checking bench for cash_fill_controller: table of transactions against a cache/memory
// model with a response scoreboard, plus hand-written reset-abort and saturation sequences.
module tb_cash_fill_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid, req_ready;
    logic [3:0] req_address;
    logic       rsp_valid, rsp_ready;
    logic [3:0] rsp_data;
    logic       rsp_hit, rsp_error;
    logic [3:0] cache_address;
    logic       cache_hit;
    logic [3:0] cache_data;
    logic       cache_write;
    logic [3:0] cache_wdata;
    logic       mem_req;
    logic [3:0] mem_address;
    logic       mem_ack;
    logic [3:0] mem_data;
    logic [7:0] hit_count, miss_count;

    always #5 clk = ~clk;

    cash_fill_controller #(
        .address_size  (4),
        .data_size     (4),
        .timeout_width (4),
        .stat_width    (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_address   (req_address),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_hit       (rsp_hit),
        .rsp_error     (rsp_error),
        .cache_address (cache_address),
        .cache_hit     (cache_hit),
        .cache_data    (cache_data),
        .cache_write   (cache_write),
        .cache_wdata   (cache_wdata),
        .mem_req       (mem_req),
        .mem_address   (mem_address),
        .mem_ack       (mem_ack),
        .mem_data      (mem_data),
        .hit_count     (hit_count),
        .miss_count    (miss_count)
    );

    // Cache model contents, maintained by the bench from its own expectations.
    logic       cache_valid [16];
    logic [3:0] cache_mem   [16];
    assign cache_hit  = cache_valid[cache_address];
    assign cache_data = cache_mem[cache_address];

    typedef struct {
        logic [3:0] addr;
        int         delay;   // mem_req cycle on which ack is given; >15 means never
        int         hold;    // cycles rsp_ready stays low once rsp_valid is up
    } vec_t;

    typedef struct {
        logic [3:0] data;
        logic       hit;
        logic       err;
        int         latency;
        int         mem_cycles;
        int         writes;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_hits = 0;
    int   exp_misses = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [3:0] backing(input logic [3:0] a);
        return a + 4'd2;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    task automatic run_txn(input vec_t v);
        exp_t       e;
        int         cyc, mcyc, wr;
        logic [3:0] wa, wd;
        bit         seen;
        if (cache_valid[v.addr]) begin
            e = '{cache_mem[v.addr], 1'b1, 1'b0, 2, 0, 0};
            exp_hits = sat_inc(exp_hits);
        end else if (v.delay >= 1 && v.delay <= 15) begin
            e = '{backing(v.addr), 1'b0, 1'b0, 3 + v.delay, v.delay, 1};
            exp_misses = sat_inc(exp_misses);
        end else begin
            e = '{4'h0, 1'b0, 1'b1, 17, 15, 0};
            exp_misses = sat_inc(exp_misses);
        end
        sb.push_back(e);

        req_valid   = 1'b1;
        req_address = v.addr;
        @(negedge clk);
        req_valid = 1'b0;
        cyc  = 1;
        mcyc = 0;
        wr   = 0;
        wa   = '0;
        wd   = '0;
        seen = 1'b0;
        while (cyc < 40 && !seen) begin
            mem_ack = 1'b0;
            if (mem_req) begin
                mcyc++;
                if (mcyc == v.delay) begin
                    mem_ack  = 1'b1;
                    mem_data = backing(v.addr);
                end
            end
            if (cache_write) begin
                wr++;
                wa = cache_address;
                wd = cache_wdata;
            end
            if (rsp_valid) begin
                seen = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        mem_ack = 1'b0;
        check("rsp_valid_seen", 32'(seen), 32'd1);
        if (seen) begin
            e = sb.pop_front();
            check("latency", cyc, e.latency);
            check("mem_req_cycles", mcyc, e.mem_cycles);
            check("cache_writes", wr, e.writes);
            if (e.writes == 1) begin
                check("fill_address", 32'(wa), 32'(v.addr));
                check("fill_data", 32'(wd), 32'(e.data));
            end
            for (int i = 0; i < v.hold; i++) begin
                req_valid   = 1'b1;
                req_address = ~v.addr;
                @(negedge clk);
                check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
                check("hold_rsp_data", 32'(rsp_data), 32'(e.data));
                check("hold_req_ready", 32'(req_ready), 32'd0);
                check("hold_address", 32'(cache_address), 32'(v.addr));
            end
            req_valid = 1'b0;
            check("rsp_data", 32'(rsp_data), 32'(e.data));
            check("rsp_hit", 32'(rsp_hit), 32'(e.hit));
            check("rsp_error", 32'(rsp_error), 32'(e.err));
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            check("post_rsp_valid", 32'(rsp_valid), 32'd0);
            check("post_req_ready", 32'(req_ready), 32'd1);
            check("post_rsp_error", 32'(rsp_error), 32'd0);
            check("hit_count", 32'(hit_count), exp_hits);
            check("miss_count", 32'(miss_count), exp_misses);
            if (e.writes == 1) begin
                cache_valid[v.addr] = 1'b1;
                cache_mem[v.addr]   = e.data;
            end
        end
    endtask

    vec_t vecs[9];
    int   wr_cnt, mreq_cnt, rv_cnt;

    initial begin
        vecs[0] = '{4'h3, 0, 0};    // preloaded hit
        vecs[1] = '{4'h5, 3, 0};    // miss, ack on third wait cycle
        vecs[2] = '{4'h5, 0, 0};    // now filled: hit
        vecs[3] = '{4'h9, 99, 0};   // no ack: timeout
        vecs[4] = '{4'h9, 15, 0};   // ack on the timeout cycle wins
        vecs[5] = '{4'h9, 0, 0};    // filled by the late ack
        vecs[6] = '{4'h3, 0, 10};   // long response back-pressure
        vecs[7] = '{4'hF, 1, 0};    // fastest ack, data wraps
        vecs[8] = '{4'hC, 14, 2};

        for (int i = 0; i < 16; i++) begin
            cache_valid[i] = 1'b0;
            cache_mem[i]   = 4'h0;
        end
        cache_valid[3] = 1'b1;
        cache_mem[3]   = 4'hA;

        reset       = 1'b1;
        req_valid   = 1'b0;
        req_address = 4'h0;
        rsp_ready   = 1'b0;
        mem_ack     = 1'b0;
        mem_data    = 4'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_mem_req", 32'(mem_req), 32'd0);
        check("reset_cache_write", 32'(cache_write), 32'd0);
        check("reset_outputs", 32'({rsp_data, rsp_hit, rsp_error, cache_address, mem_address}), 32'd0);
        check("reset_counts", 32'({hit_count, miss_count}), 32'd0);

        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i]);
        end

        // Reset while waiting on memory; a late ack must be ignored.
        req_valid   = 1'b1;
        req_address = 4'h2;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("abort_mem_req", 32'(mem_req), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_mem_req_drop", 32'(mem_req), 32'd0);
        check("abort_counts", 32'({hit_count, miss_count}), 32'd0);
        mem_ack  = 1'b1;
        mem_data = 4'h5;
        wr_cnt   = 0;
        mreq_cnt = 0;
        rv_cnt   = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (cache_write) wr_cnt++;
            if (mem_req) mreq_cnt++;
            if (rsp_valid) rv_cnt++;
        end
        check("abort_no_write", wr_cnt, 0);
        check("abort_no_mem_req", mreq_cnt, 0);
        check("abort_no_rsp", rv_cnt, 0);
        check("abort_idle", 32'(req_ready), 32'd1);

        // Saturation of the hit statistic.
        for (int i = 0; i < 300; i++) begin
            run_txn('{4'h3, 0, 0});
        end
        check("hit_count_saturated", 32'(hit_count), 32'd255);
        check("miss_count_after_sat", 32'(miss_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
